stopwatch_lap: RTL

Parametrised N-digit BCD stopwatch with lap (split) capture, configurable overflow mode and a built-in multiplexed common-anode 7-segment driver. It generalises the fixed 4-digit start/stop stopwatch with three additions: digit count and timing resolution set by parameters, a lap function that freezes the display while counting continues, and a clear control. It sits at board top level, driving `sseg_ca`/`sseg_an` directly. It is checked with the `sseg_x4_monitor` for `DIGITS=4`.

---
 rtl/stopwatch_lap.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: N-digit BCD stopwatch with lap (split) capture, wrap or
// saturate overflow handling and a multiplexed common-anode 7-segment driver.
//
// Ports:
//   clk100MHz  in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   start/resume request (level, asynchronous)
//   stop       in   pause request (level, asynchronous)
//   lap        in   lap capture request (level, asynchronous)
//   clear      in   zero request (level, asynchronous)
//   sseg_ca    out  cathodes {g,f,e,d,c,b,a}, active-low, registered
//   sseg_an    out  anodes, active-low, an[0] = rightmost digit, registered
//   running    out  high in RUN and SPLIT, registered
//   overflow   out  sticky overflow flag, registered
module stopwatch_lap #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned REFRESH_HZ  = 1000,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned WRAP        = 1
) (
  input  logic              clk100MHz,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              lap,
  input  logic              clear,
  output logic [6:0]        sseg_ca,
  output logic [DIGITS-1:0] sseg_an,
  output logic              running,
  output logic              overflow
);

  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned SCAN_DIV = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit          SATURATE = (WRAP == 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_SPLIT  = 2'd3
  } state_e;

  // Request bit order: {clear, start, lap, stop}
  logic [3:0] req;
  logic [3:0] sync1_q, sync2_q, sync3_q, evt_q;

  logic stop_ev, lap_ev, start_ev, clear_ev;

  state_e state_q, state_d;
  logic   counting, tick, all_nines, clear_go;

  logic [TICK_W-1:0]        tick_cnt_q;
  logic [DIGITS-1:0][3:0]   count_q, lap_q, count_inc, disp_val;

  logic [SCAN_W-1:0] scan_cnt_q;
  logic [IDX_W-1:0]  scan_idx_q;
  logic [3:0]        cur_digit;

  assign req = {clear, start, lap, stop};

  // Two-stage synchronizer followed by a registered rising-edge detector
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      evt_q   <= '0;
    end else begin
      sync1_q <= req;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      evt_q   <= sync2_q & ~sync3_q;
    end
  end

  // Only the highest-priority event of a cycle is allowed to act
  assign stop_ev  = evt_q[0];
  assign lap_ev   = evt_q[1] & ~evt_q[0];
  assign start_ev = evt_q[2] & ~(|evt_q[1:0]);
  assign clear_ev = evt_q[3] & ~(|evt_q[2:0]);

  assign counting = (state_q == S_RUN) || (state_q == S_SPLIT);
  assign tick     = counting && (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  // Ripple-carry BCD increment; a carry out of the top digit means all-9s
  always_comb begin
    logic carry;
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (count_q[i] == 4'd9) begin
          count_inc[i] = 4'd0;
        end else begin
          count_inc[i] = count_q[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  // Next state; saturating overflow forces PAUSED regardless of events
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ev) state_d = S_RUN;
      S_RUN: begin
        if (stop_ev)     state_d = S_PAUSED;
        else if (lap_ev) state_d = S_SPLIT;
      end
      S_SPLIT:  if (stop_ev) state_d = S_PAUSED;
      S_PAUSED: begin
        if (start_ev)      state_d = S_RUN;
        else if (clear_ev) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
    if (SATURATE && tick && all_nines) state_d = S_PAUSED;
  end

  assign clear_go = (state_q == S_PAUSED) && (state_d == S_IDLE);

  // State, prescaler, count, lap register and status flags
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      count_q    <= '0;
      lap_q      <= '0;
      running    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == S_RUN) || (state_d == S_SPLIT);

      // Prescaler holds in PAUSED so a partial tick resumes later
      if (clear_go) begin
        tick_cnt_q <= '0;
      end else if (counting) begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_W'(1);
      end

      if (clear_go) begin
        count_q <= '0;
      end else if (tick && !(SATURATE && all_nines)) begin
        count_q <= count_inc;
      end

      // Captures the pre-increment value when a tick coincides
      if (lap_ev && counting) lap_q <= count_q;

      if (clear_ev && ((state_q == S_IDLE) || clear_go)) begin
        overflow <= 1'b0;
      end else if (tick && all_nines) begin
        overflow <= 1'b1;
      end
    end
  end

  // Digit scan timebase
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      scan_idx_q <= (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

  assign disp_val = (state_q == S_SPLIT) ? lap_q : count_q;

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scan_idx_q == IDX_W'(i)) cur_digit = disp_val[i];
    end
  end

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = 7'b1111111;
    endcase
  endfunction

  // Registered segment/anode drive
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      sseg_ca <= 7'b1111111;
      sseg_an <= '1;
    end else begin
      sseg_ca <= bcd_to_seg(cur_digit);
      sseg_an <= ~(DIGITS'(1) << scan_idx_q);
    end
  end

endmodule
